// File: rtl/comp_pkg.sv
// Shared definitions for the sequential slice-by-slice comparator.
package comp_pkg;

    // Controller states: waiting for a request, or walking the slices.
    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } cmp_state_t;

    // Default operand width and number of bits examined per clock.
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 8;

endpackage

// File: rtl/slice_cmp.sv
// Combinational unsigned magnitude compare of one SLICE-bit pair.
module slice_cmp #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    // Exactly one of the three outputs is high for any input pair.
    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: examines the captured operands one
// SLICE-bit chunk per clock from the MSB end and stops at the first
// chunk that differs.
module seq_comparator
    import comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             le,
    output logic             eq,
    output logic             gr
);

    localparam int NSLICE = (SLICE >= 1) ? (WIDTH / SLICE) : 1;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0]    LAST_IDX = KW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = ONE_W << (WIDTH - 1);

    // Refuse to build with a slice size that does not tile the operand.
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("seq_comparator: WIDTH must be a positive multiple of SLICE");
    end

    cmp_state_t       state;
    cmp_state_t       nextState;
    logic [KW-1:0]    sliceIdx;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             resolve;
    logic             sliceLt;
    logic             sliceEq;
    logic             sliceGt;

    // Operands are shifted left as slices are consumed, so the slice
    // under examination always sits in the top SLICE bits.
    slice_cmp #(
        .SLICE(SLICE)
    ) u_slice_cmp (
        .a  (opA[WIDTH-1 -: SLICE]),
        .b  (opB[WIDTH-1 -: SLICE]),
        .lt (sliceLt),
        .eq (sliceEq),
        .gt (sliceGt)
    );

    assign busy = (state == CMP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: finish on the first differing slice or after the last one.
    always_comb begin
        nextState = state;
        resolve   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = CMP;
                end
            end
            CMP: begin
                if (!sliceEq || sliceIdx == LAST_IDX) begin
                    nextState = IDLE;
                    resolve   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: capture with sign bias, step through slices, latch the verdict.
    // Flipping both MSBs turns a two's-complement compare into an unsigned one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sliceIdx <= '0;
            opA      <= '0;
            opB      <= '0;
            done     <= 1'b0;
            le       <= 1'b0;
            eq       <= 1'b0;
            gr       <= 1'b0;
        end else begin
            done <= resolve;
            if (state == IDLE && start) begin
                opA      <= is_signed ? (in1 ^ MSB_MASK) : in1;
                opB      <= is_signed ? (in2 ^ MSB_MASK) : in2;
                sliceIdx <= '0;
            end else if (state == CMP) begin
                if (resolve) begin
                    le <= sliceLt;
                    eq <= sliceEq;
                    gr <= sliceGt;
                end else begin
                    opA      <= opA << SLICE;
                    opB      <= opB << SLICE;
                    sliceIdx <= sliceIdx + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator (WIDTH=32, SLICE=8) using a
// behavioural reference built from signed/unsigned arithmetic.
module tb_seq_comparator;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic             le;
    logic             eq;
    logic             gr;

    int checks   = 0;
    int failures = 0;

    seq_comparator #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .done      (done),
        .le        (le),
        .eq        (eq),
        .gr        (gr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference: the result is the arithmetic order of the operands, and the
    // latency is the slice (from the MSB end) holding the highest differing bit.
    function automatic void refCompare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sgn, output int lat,
                                       output logic [2:0] flags);
        logic [WIDTH-1:0] diff;
        int topBit;
        diff   = a ^ b;
        topBit = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (diff[i]) topBit = i;
        end
        if (topBit < 0) lat = NSLICE;
        else            lat = (WIDTH - 1 - topBit) / SLICE + 1;
        if (sgn) flags = {($signed(a) < $signed(b)), (a == b), ($signed(a) > $signed(b))};
        else     flags = {(a < b), (a == b), (a > b)};
    endfunction

    // Called #1 after the accepting edge; follows the comparison to its done pulse.
    task automatic waitResult(input string tag, input int expLat, input logic [2:0] expFlags,
                              input bit scramble);
        int edges      = 0;
        int busyCycles = 1;
        bit seen       = 0;
        checkOutput({tag, "_busy_on_accept"}, busy, 1'b1);
        while (!seen && edges < NSLICE + 4) begin
            if (scramble) begin
                in1       = $urandom;
                in2       = $urandom;
                is_signed = 1'($urandom);
                start     = 1'($urandom);
            end
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1;
            else if (busy) busyCycles++;
        end
        if (scramble) start = 1'b0;
        checkOutput({tag, "_done_seen"}, seen, 1'b1);
        checkOutput({tag, "_latency"}, edges, expLat);
        checkOutput({tag, "_busy_cycles"}, busyCycles, expLat);
        checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
        checkOutput({tag, "_flags"}, {le, eq, gr}, expFlags);
    endtask

    // One full transaction from idle, plus pulse-width and flag-hold checks.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic sgn,
                                 input bit scramble);
        int         lat;
        logic [2:0] flags;
        refCompare(a, b, sgn, lat, flags);
        @(negedge clk);
        in1 = a; in2 = b; is_signed = sgn; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitResult(tag, lat, flags, scramble);
        @(posedge clk); #1;
        checkOutput({tag, "_done_one_cycle"}, done, 1'b0);
        checkOutput({tag, "_flags_hold"}, {le, eq, gr}, flags);
    endtask

    // Stimulus sequence: reset, directed cases, back-to-back, reset abort, random.
    initial begin
        int         lat;
        logic [2:0] flags;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; in1 = '0; in2 = '0;
        #1;
        checkOutput("reset_outputs", {busy, done, le, eq, gr}, 5'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        applyStimulus("unsigned_lt_last", 32'h12345678, 32'h12345679, 1'b0, 0);
        applyStimulus("unsigned_msb_gt",  32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
        applyStimulus("signed_msb_lt",    32'h80000000, 32'h7FFFFFFF, 1'b1, 0);
        applyStimulus("signed_eq",        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0);
        applyStimulus("unsigned_eq",      32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);

        // Restart and input changes while busy must be ignored.
        refCompare(32'h01000000, 32'h01000001, 1'b0, lat, flags);
        @(negedge clk);
        in1 = 32'h01000000; in2 = 32'h01000001; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        in1 = 32'hFFFFFFFF; in2 = 32'h00000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in1 = ~in1;
        waitResult("ignore_restart", lat - 1, flags, 0);
        @(posedge clk); #1;
        checkOutput("ignore_restart_single_done", {done, busy}, 2'b00);

        // Back-to-back: start held through the done cycle.
        @(negedge clk);
        in1 = 32'h00000010; in2 = 32'h00000020; is_signed = 1'b0; start = 1'b1;
        refCompare(32'h00000010, 32'h00000020, 1'b0, lat, flags);
        @(posedge clk); #1;
        in1 = 32'hF0000000; in2 = 32'h10000000; is_signed = 1'b1;
        waitResult("b2b_first", lat, flags, 0);
        refCompare(32'hF0000000, 32'h10000000, 1'b1, lat, flags);
        @(posedge clk); #1;
        start = 1'b0;
        waitResult("b2b_second", lat, flags, 0);

        // Reset two edges into a four-slice compare.
        @(negedge clk);
        in1 = 32'hCAFEF00D; in2 = 32'hCAFEF00D; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_abort_outputs", {busy, done, le, eq, gr}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int donePulses = 0;
            for (int i = 0; i < NSLICE + 2; i++) begin
                @(posedge clk); #1;
                if (done) donePulses++;
            end
            checkOutput("reset_abort_no_done", donePulses, 0);
        end
        applyStimulus("after_reset_gt", 32'h00000005, 32'h00000003, 1'b0, 0);

        // Randomized transactions, biased towards shared leading slices.
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'h1 << $urandom_range(0, WIDTH - 1));
                2:       b = {a[31:16], 16'($urandom)};
                default: b = $urandom;
            endcase
            applyStimulus($sformatf("rand%0d", n), a, b, 1'($urandom), 1'($urandom));
        end

        $display("[TB] done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
